// File: rtl/dom1_skinny_unmask.sv
// Unmasking stage behind the first-order DOM Skinny core: XOR-recombines the two
// state shares of each output frame and streams the 16 ciphertext bytes out.
module dom1_skinny_unmask #(
    parameter int FRAME_BYTES = 112,
    parameter int SHARE_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] si_data,
    input  logic       si_valid,
    output logic       si_ready,
    output logic [7:0] so_data,
    output logic       so_valid,
    input  logic       so_ready,
    output logic       frame_done
);

    localparam int BW          = 8 * SHARE_BYTES;
    localparam int DRAIN_BYTES = FRAME_BYTES - 2 * SHARE_BYTES;
    localparam logic [6:0] SHARE_LAST = 7'(SHARE_BYTES - 1);
    localparam logic [6:0] DRAIN_LAST = 7'((DRAIN_BYTES > 0) ? (DRAIN_BYTES - 1) : 0);

    typedef enum logic [1:0] {
        LOAD_S1 = 2'd0,
        LOAD_S0 = 2'd1,
        DRAIN   = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [6:0]     cnt;
    logic [6:0]     cnt_nxt;
    logic [BW-1:0]  data_buf;
    logic [BW-1:0]  buf_nxt;
    logic           frame_done_nxt;
    logic           in_xfer;
    logic           out_xfer;

    // Handshake qualifiers depend only on registered state, never on the partner's inputs.
    assign si_ready = (state != EMIT);
    assign so_valid = (state == EMIT);
    assign so_data  = data_buf[BW-1 -: 8];
    assign in_xfer  = si_valid && si_ready;
    assign out_xfer = so_valid && so_ready;

    // Next-state, counter and buffer update logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        buf_nxt        = data_buf;
        frame_done_nxt = 1'b0;
        case (state)
            LOAD_S1: begin
                if (in_xfer) begin
                    buf_nxt = {data_buf[BW-9:0], si_data};
                    if (cnt == SHARE_LAST) begin
                        state_nxt = LOAD_S0;
                        cnt_nxt   = 7'd0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end else begin
                    buf_nxt = data_buf;
                end
            end
            LOAD_S0: begin
                if (in_xfer) begin
                    // Rotating the XOR result to the bottom keeps share-1 byte order intact.
                    buf_nxt = {data_buf[BW-9:0], data_buf[BW-1 -: 8] ^ si_data};
                    if (cnt == SHARE_LAST) begin
                        cnt_nxt = 7'd0;
                        if (DRAIN_BYTES > 0) begin
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = EMIT;
                        end
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end else begin
                    buf_nxt = data_buf;
                end
            end
            DRAIN: begin
                if (in_xfer) begin
                    if (cnt == DRAIN_LAST) begin
                        state_nxt = EMIT;
                        cnt_nxt   = 7'd0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end else begin
                    cnt_nxt = cnt;
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    // Zero-fill so no ciphertext lingers once it has been handed off.
                    buf_nxt = {data_buf[BW-9:0], 8'h00};
                    if (cnt == SHARE_LAST) begin
                        state_nxt      = LOAD_S1;
                        cnt_nxt        = 7'd0;
                        frame_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end else begin
                    buf_nxt = data_buf;
                end
            end
            default: begin
                state_nxt = LOAD_S1;
                cnt_nxt   = 7'd0;
                buf_nxt   = '0;
            end
        endcase
    end

    // State, counter, buffer and frame_done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_S1;
            cnt        <= 7'd0;
            data_buf   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_buf   <= buf_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_dom1_skinny_unmask.sv
// Randomized scoreboard bench for dom1_skinny_unmask (default and 32-byte-frame instances).
module tb_dom1_skinny_unmask;

    localparam int FB = 112;
    localparam int SB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] si_data;
    logic       si_valid;
    logic       si_ready;
    logic [7:0] so_data;
    logic       so_valid;
    logic       so_ready;
    logic       frame_done;

    logic [7:0] a_si_data;
    logic       a_si_valid;
    logic       a_si_ready;
    logic [7:0] a_so_data;
    logic       a_so_valid;
    logic       a_so_ready;
    logic       a_frame_done;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] q32[$];
    int rdy_mode  = 0;
    int rdy_phase = 0;
    int done_cnt  = 0;
    int a_done_cnt = 0;
    int pops_since = 0;
    logic [3:0] rdy_pat = 4'b1001;

    always #5 clk = ~clk;

    dom1_skinny_unmask #(.FRAME_BYTES(FB), .SHARE_BYTES(SB)) dut (
        .clk(clk), .rst(rst), .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
        .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready), .frame_done(frame_done)
    );

    dom1_skinny_unmask #(.FRAME_BYTES(32), .SHARE_BYTES(SB)) dut32 (
        .clk(clk), .rst(rst), .si_data(a_si_data), .si_valid(a_si_valid), .si_ready(a_si_ready),
        .so_data(a_so_data), .so_valid(a_so_valid), .so_ready(a_so_ready), .frame_done(a_frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Downstream ready pattern: always ready, or the repeating 1,0,0,1 sequence.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            so_ready = rdy_pat[rdy_phase % 4];
            rdy_phase++;
        end else begin
            so_ready = 1'b1;
        end
    end

    // Monitor for the default instance: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (so_valid) chk("si_ready_in_emit", {31'd0, si_ready}, 32'd0);
            if (so_valid && so_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0h expected no output", so_data);
                end else begin
                    chk("so_data", {24'd0, so_data}, {24'd0, exp_q.pop_front()});
                    pops_since++;
                end
            end
            if (frame_done) begin
                done_cnt++;
                chk("bytes_per_frame", pops_since, 32'd16);
                pops_since = 0;
            end
        end
    end

    // Monitor for the 32-byte-frame instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_so_valid && a_so_ready) begin
                if (q32.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out32: got %0h expected no output", a_so_data);
                end else begin
                    chk("so_data32", {24'd0, a_so_data}, {24'd0, q32.pop_front()});
                end
            end
            if (a_frame_done) a_done_cnt++;
        end
    end

    // Reference: ciphertext byte i is frame byte i XOR frame byte SB+i.
    task automatic push_expected(input logic [7:0] fr[]);
        for (int i = 0; i < SB; i++) exp_q.push_back(fr[i] ^ fr[SB + i]);
    endtask

    task automatic send_frame(input logic [7:0] fr[], input int n, input int vpct, input bit chk_b2b);
        int i = 0;
        int guard = 0;
        while (i < n) begin
            @(posedge clk); #1;
            if (int'($urandom_range(99)) < vpct) begin
                si_valid = 1'b1;
                si_data  = fr[i];
            end else begin
                si_valid = 1'b0;
                si_data  = 8'($urandom);
            end
            @(negedge clk);
            if (si_valid && si_ready) begin
                if (i == 0 && chk_b2b) chk("b2b_first_in_done_cycle", {31'd0, frame_done}, 32'd1);
                i++;
            end
            guard++;
            if (guard > 5000) begin
                total++; bad++;
                $display("FAIL send_timeout: got %0d bytes expected %0d", i, n);
                break;
            end
        end
        @(posedge clk); #1;
        si_valid = 1'b0;
        if (i == FB) chk("latency_so_valid", {31'd0, so_valid}, 32'd1);
    endtask

    task automatic wait_empty();
        int c = 0;
        while ((exp_q.size() != 0 || q32.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + q32.size());
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        si_data  = 8'($urandom);
        si_valid = 1'($urandom);
        rst = 1'b1;
        #1;
        chk("rst_so_valid", {31'd0, so_valid}, 32'd0);
        chk("rst_so_data", {24'd0, so_data}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_si_ready", {31'd0, si_ready}, 32'd1);
        chk("rst_buf", {31'd0, (dut.data_buf == '0)}, 32'd1);
        pops_since = 0;
        @(posedge clk); #2;
        si_valid = 1'b0;
        rst = 1'b0;
    endtask

    function automatic void rand_frame(output logic [7:0] fr[], input logic [7:0] drain_val);
        fr = new[FB];
        for (int i = 0; i < FB; i++) fr[i] = (i < 2 * SB) ? 8'($urandom) : drain_val;
    endfunction

    initial begin
        logic [7:0] f0[];
        logic [7:0] f1[];
        logic [7:0] f2[];
        rst = 1'b1; si_valid = 1'b0; si_data = 8'h00; so_ready = 1'b1;
        a_si_valid = 1'b0; a_si_data = 8'h00; a_so_ready = 1'b1;
        #12 rst = 1'b0;

        do_reset();

        // Directed frame: share1 00..0F, share0 A5, drain FF.
        f0 = new[FB];
        for (int i = 0; i < FB; i++) f0[i] = (i < SB) ? 8'(i) : ((i < 2 * SB) ? 8'hA5 : 8'hFF);
        push_expected(f0);
        send_frame(f0, FB, 100, 1'b0);
        wait_empty();

        // Backpressure plus random input gaps.
        rdy_mode = 1;
        push_expected(f0);
        send_frame(f0, FB, 50, 1'b0);
        wait_empty();
        rdy_mode = 0;

        // Back-to-back frames; drain bytes chosen to differ from any ciphertext check.
        rand_frame(f1, 8'h3C);
        rand_frame(f2, 8'hC3);
        push_expected(f1);
        send_frame(f1, FB, 100, 1'b0);
        push_expected(f2);
        send_frame(f2, FB, 100, 1'b1);
        wait_empty();

        // Abort a frame after 20 bytes; only the following frame may emit.
        rand_frame(f1, 8'h77);
        send_frame(f1, 20, 100, 1'b0);
        do_reset();
        rand_frame(f2, 8'h11);
        push_expected(f2);
        send_frame(f2, FB, 100, 1'b0);
        wait_empty();

        // 32-byte frame instance: no drain phase, so output starts right after byte 31.
        for (int i = 0; i < SB; i++) q32.push_back(8'hFF ^ 8'h0F);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            a_si_valid = 1'b1;
            a_si_data  = (i < SB) ? 8'hFF : 8'h0F;
        end
        @(posedge clk); #1;
        a_si_valid = 1'b0;
        chk("latency32_so_valid", {31'd0, a_so_valid}, 32'd1);
        wait_empty();

        chk("frames_done", done_cnt, 32'd5);
        chk("frames_done32", a_done_cnt, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
